// File: rtl/max11046_frame_reader_if.sv
// Pin and sample bundle between the MAX11046 frame reader and its neighbours.
// slave = reader side, master = ADC/consumer side.
interface max11046_frame_reader_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 3
);
    logic              start;
    logic              cont_en;
    logic              pwr_down;
    logic              end_of_con;
    logic [DATA_W-1:0] db_in;
    logic              conv_start;
    logic              chip_sel;
    logic              write;
    logic              read_s;
    logic              shutd;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              frame_done;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  start, cont_en, pwr_down, end_of_con, db_in,
        output conv_start, chip_sel, write, read_s, shutd,
        output sample_data, sample_ch, sample_valid,
        output frame_done, busy, timeout_err
    );

    modport master (
        output start, cont_en, pwr_down, end_of_con, db_in,
        input  conv_start, chip_sel, write, read_s, shutd,
        input  sample_data, sample_ch, sample_valid,
        input  frame_done, busy, timeout_err
    );
endinterface

// File: rtl/max11046_frame_reader.sv
// MAX11046 frame reader: CONVST, EOC wait, then NUM_CH parallel reads.
// Every pin and strobe is registered from the next-state logic.
module max11046_frame_reader #(
    parameter int NUM_CH          = 8,
    parameter int DATA_W          = 16,
    parameter int CONV_LOW_CYC    = 5,
    parameter int CS_SETUP_CYC    = 2,
    parameter int RD_LOW_CYC      = 4,
    parameter int RD_HIGH_CYC     = 2,
    parameter int EOC_TIMEOUT_CYC = 200,
    parameter int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic clock1,
    input  logic reset,
    max11046_frame_reader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CONV, WAIT_EOC, CS_SETUP, RD_LOW, RD_HIGH, DONE
    } state_t;

    localparam logic [31:0] CONV_LAST = 32'(CONV_LOW_CYC - 1);
    localparam logic [31:0] EOC_LAST  = 32'(EOC_TIMEOUT_CYC - 1);
    localparam logic [31:0] CS_LAST   = 32'(CS_SETUP_CYC - 1);
    localparam logic [31:0] RDL_LAST  = 32'(RD_LOW_CYC - 1);
    localparam logic [31:0] RDH_LAST  = 32'(RD_HIGH_CYC - 1);
    localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic              eoc_meta_q, eoc_sync_q;
    logic              conv_start_q, conv_start_d;
    logic              chip_sel_q, chip_sel_d;
    logic              read_s_q, read_s_d;
    logic              shutd_q, shutd_d;
    logic [DATA_W-1:0] sample_data_q, sample_data_d;
    logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
    logic              sample_valid_q, sample_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 32'd1;
        idx_d          = idx_q;
        conv_start_d   = conv_start_q;
        chip_sel_d     = chip_sel_q;
        read_s_d       = read_s_q;
        shutd_d        = shutd_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                shutd_d = ~bus.pwr_down;
                if (bus.start && !bus.pwr_down) begin
                    state_d       = CONV;
                    timeout_err_d = 1'b0;
                    conv_start_d  = 1'b0;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d      = WAIT_EOC;
                    cnt_d        = '0;
                    conv_start_d = 1'b1;
                end
            end
            WAIT_EOC: begin
                // a level already low on entry is taken as the event
                if (!eoc_sync_q) begin
                    state_d    = CS_SETUP;
                    cnt_d      = '0;
                    chip_sel_d = 1'b0;
                end else if (cnt_q == EOC_LAST) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end
            end
            CS_SETUP: begin
                if (cnt_q == CS_LAST) begin
                    state_d  = RD_LOW;
                    cnt_d    = '0;
                    idx_d    = '0;
                    read_s_d = 1'b0;
                end
            end
            RD_LOW: begin
                if (cnt_q == RDL_LAST) begin
                    state_d        = RD_HIGH;
                    cnt_d          = '0;
                    read_s_d       = 1'b1;
                    sample_data_d  = bus.db_in;
                    sample_ch_d    = idx_q;
                    sample_valid_d = 1'b1;
                end
            end
            RD_HIGH: begin
                if (cnt_q == RDH_LAST) begin
                    cnt_d = '0;
                    if (idx_q < IDX_LAST) begin
                        state_d  = RD_LOW;
                        idx_d    = idx_q + CH_W'(1);
                        read_s_d = 1'b0;
                    end else begin
                        state_d      = DONE;
                        chip_sel_d   = 1'b1;
                        frame_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
                if (bus.cont_en && !bus.pwr_down) begin
                    state_d      = CONV;
                    conv_start_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            eoc_meta_q     <= 1'b1;
            eoc_sync_q     <= 1'b1;
            conv_start_q   <= 1'b1;
            chip_sel_q     <= 1'b1;
            read_s_q       <= 1'b1;
            shutd_q        <= 1'b1;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            eoc_meta_q     <= bus.end_of_con;
            eoc_sync_q     <= eoc_meta_q;
            conv_start_q   <= conv_start_d;
            chip_sel_q     <= chip_sel_d;
            read_s_q       <= read_s_d;
            shutd_q        <= shutd_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.conv_start   = conv_start_q;
    assign bus.chip_sel     = chip_sel_q;
    assign bus.write        = 1'b1;
    assign bus.read_s       = read_s_q;
    assign bus.shutd        = shutd_q;
    assign bus.sample_data  = sample_data_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_max11046_frame_reader.sv
// Scoreboard bench for max11046_frame_reader: default instance plus a
// one-channel, one-cycle-RD instance.
module tb_max11046_frame_reader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    max11046_frame_reader_if #(.DATA_W(16), .CH_W(3)) ia ();
    max11046_frame_reader_if #(.DATA_W(16), .CH_W(1)) ib ();

    max11046_frame_reader dut_a (
        .clock1(clk), .reset(reset), .bus(ia.slave)
    );
    max11046_frame_reader #(.NUM_CH(1), .RD_LOW_CYC(1)) dut_b (
        .clock1(clk), .reset(reset), .bus(ib.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no event within cycle budget @%0t", nm, $time);
    endtask

    // ADC models: EOC falls a fixed delay after CONVST rises, rises on first RD
    logic        eoc_a = 1'b1, eoc_b = 1'b1;
    logic [15:0] db_a = '0;
    int eoc_lim_a = 0, eoc_given_a = 0, dly_a = 0, rd_idx_a = 0;
    int eoc_lim_b = 0, eoc_given_b = 0, dly_b = 0;
    logic cv_pa = 1'b1, rd_pa = 1'b1, cv_pb = 1'b1;

    assign ia.end_of_con = eoc_a;
    assign ia.db_in      = db_a;
    assign ib.end_of_con = eoc_b;
    assign ib.db_in      = 16'h5A5A;

    always @(negedge clk) begin
        if (ia.conv_start && !cv_pa && eoc_given_a < eoc_lim_a) begin
            eoc_given_a++;
            dly_a = 20;
        end else if (dly_a > 0) begin
            dly_a--;
            if (dly_a == 0) eoc_a = 1'b0;
        end
        if (!ia.read_s && rd_pa) begin
            eoc_a = 1'b1;
            db_a = 16'hA000 + 16'(rd_idx_a);
            rd_idx_a++;
        end
        if (ia.chip_sel) rd_idx_a = 0;
        cv_pa = ia.conv_start;
        rd_pa = ia.read_s;
    end

    always @(negedge clk) begin
        if (ib.conv_start && !cv_pb && eoc_given_b < eoc_lim_b) begin
            eoc_given_b++;
            dly_b = 3;
        end else if (dly_b > 0) begin
            dly_b--;
            if (dly_b == 0) eoc_b = 1'b0;
        end
        if (!ib.read_s) eoc_b = 1'b1;
        cv_pb = ib.conv_start;
    end

    // scoreboards and pin-timing monitors
    int exp_d_a[$], exp_c_a[$], exp_d_b[$], exp_c_b[$];
    int cyc = 0, last_va = 0, last_vb = 0, fd_a = 0, fd_b = 0;
    int conv_run = 0, rdl_run = 0, rdh_run = 0;
    bit seen_rd = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            conv_run = 0; rdl_run = 0; rdh_run = 0; seen_rd = 0;
        end else begin
            if (ia.sample_valid) begin
                if (exp_d_a.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL a_extra_sample: got ch %0d data %h, expected none",
                             ia.sample_ch, ia.sample_data);
                end else begin
                    chk("a_data", ia.sample_data, exp_d_a.pop_front());
                    chk("a_ch", ia.sample_ch, exp_c_a.pop_front());
                end
                last_va = cyc;
            end
            if (ia.frame_done) begin
                fd_a++;
                chk("a_fd_gap", cyc - last_va, 2);
            end
            if (!ia.conv_start) conv_run++;
            else begin
                if (conv_run > 0) chk("a_conv_low", conv_run, 5);
                conv_run = 0;
            end
            if (!ia.read_s) begin
                if (rdh_run > 0) chk("a_rd_high", rdh_run, 2);
                rdh_run = 0;
                rdl_run++;
            end else begin
                if (rdl_run > 0) begin
                    chk("a_rd_low", rdl_run, 4);
                    chk("a_cs_during_rd", ia.chip_sel, 0);
                    seen_rd = 1;
                end
                rdl_run = 0;
                if (ia.chip_sel) begin
                    seen_rd = 0; rdh_run = 0;
                end else if (seen_rd) rdh_run++;
            end
            if (ib.sample_valid) begin
                if (exp_d_b.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_extra_sample: got ch %0d data %h, expected none",
                             ib.sample_ch, ib.sample_data);
                end else begin
                    chk("b_data", ib.sample_data, exp_d_b.pop_front());
                    chk("b_ch", ib.sample_ch, exp_c_b.pop_front());
                end
                last_vb = cyc;
            end
            if (ib.frame_done) begin
                fd_b++;
                chk("b_fd_gap", cyc - last_vb, 2);
            end
        end
    end

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) begin
            exp_d_a.push_back(32'hA000 + (i % 8));
            exp_c_a.push_back(i % 8);
        end
    endtask

    task automatic pulse_a();
        @(negedge clk) ia.start = 1'b1;
        @(negedge clk) ia.start = 1'b0;
    endtask

    task automatic wait_fd_a(input string nm);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ia.frame_done) break;
        end
        if (k == 400) tmo(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, fd0, nfall;
        bit bad, prevr;
        ia.start = 0; ia.cont_en = 0; ia.pwr_down = 0;
        ib.start = 0; ib.cont_en = 0; ib.pwr_down = 0;
        #1 reset = 1'b1;
        #1;
        chk("rst_conv_start", ia.conv_start, 1);
        chk("rst_chip_sel", ia.chip_sel, 1);
        chk("rst_write", ia.write, 1);
        chk("rst_read_s", ia.read_s, 1);
        chk("rst_shutd", ia.shutd, 1);
        chk("rst_sample_data", ia.sample_data, 0);
        chk("rst_sample_ch", ia.sample_ch, 0);
        chk("rst_sample_valid", ia.sample_valid, 0);
        chk("rst_frame_done", ia.frame_done, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_timeout_err", ia.timeout_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // single frame
        fd0 = fd_a;
        push_a(8);
        eoc_lim_a = eoc_given_a + 1;
        pulse_a();
        chk("t1_busy_running", ia.busy, 1);
        wait_fd_a("t1_frame_done");
        @(negedge clk);
        chk("t1_busy_idle", ia.busy, 0);
        chk("t1_left_in_queue", exp_d_a.size(), 0);
        chk("t1_frames", fd_a - fd0, 1);

        // EOC never arrives
        pulse_a();
        for (k = 0; k < 20 && !ia.conv_start; k++) @(negedge clk);
        bad = 0;
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!ia.chip_sel || !ia.read_s) bad = 1;
            if (ia.timeout_err) break;
        end
        chk("t2_timeout_cycles", k, 200);
        chk("t2_pins_quiet", bad, 0);
        @(negedge clk);
        chk("t2_busy_idle", ia.busy, 0);
        chk("t2_err_sticky", ia.timeout_err, 1);
        push_a(8);
        eoc_lim_a = eoc_given_a + 1;
        pulse_a();
        chk("t2_err_cleared", ia.timeout_err, 0);
        wait_fd_a("t2_recover_frame");

        // continuous mode, three frames
        repeat (3) @(negedge clk);
        fd0 = fd_a;
        ia.cont_en = 1'b1;
        push_a(24);
        eoc_lim_a = eoc_given_a + 3;
        pulse_a();
        wait_fd_a("t3_frame1");
        @(negedge clk);
        chk("t3_conv_after_fd1", ia.conv_start, 0);
        wait_fd_a("t3_frame2");
        @(negedge clk);
        chk("t3_conv_after_fd2", ia.conv_start, 0);
        ia.cont_en = 1'b0;
        wait_fd_a("t3_frame3");
        @(negedge clk);
        chk("t3_conv_after_fd3", ia.conv_start, 1);
        chk("t3_busy_idle", ia.busy, 0);
        repeat (30) @(negedge clk);
        chk("t3_frames", fd_a - fd0, 3);
        chk("t3_left_in_queue", exp_d_a.size(), 0);

        // reset during the 4th RD low phase
        fd0 = fd_a;
        push_a(3);
        eoc_lim_a = eoc_given_a + 1;
        pulse_a();
        nfall = 0; prevr = 1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!ia.read_s && prevr) nfall++;
            prevr = ia.read_s;
            if (nfall == 4) break;
        end
        if (k == 300) tmo("t4_fourth_read");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_read_s", ia.read_s, 1);
        chk("t4_chip_sel", ia.chip_sel, 1);
        chk("t4_conv_start", ia.conv_start, 1);
        chk("t4_busy", ia.busy, 0);
        chk("t4_valid", ia.sample_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_left_in_queue", exp_d_a.size(), 0);
        chk("t4_no_frame_done", fd_a - fd0, 0);

        // start held while busy
        fd0 = fd_a;
        push_a(8);
        eoc_lim_a = eoc_given_a + 1;
        @(negedge clk) ia.start = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ia.frame_done) break;
        end
        if (k == 400) tmo("t5_frame_done");
        ia.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_busy_idle", ia.busy, 0);
        chk("t5_frames", fd_a - fd0, 1);
        chk("t5_left_in_queue", exp_d_a.size(), 0);
        ia.pwr_down = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_shutd_low", ia.shutd, 0);
        pulse_a();
        repeat (10) @(negedge clk);
        chk("t5_pd_blocks_start", ia.busy, 0);
        ia.pwr_down = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_shutd_high", ia.shutd, 1);

        // one channel, one-cycle RD
        exp_d_b.push_back(32'h5A5A);
        exp_c_b.push_back(0);
        eoc_lim_b = eoc_given_b + 1;
        @(negedge clk) ib.start = 1'b1;
        @(negedge clk) ib.start = 1'b0;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (ib.frame_done) break;
        end
        if (k == 300) tmo("t6_frame_done");
        repeat (5) @(negedge clk);
        chk("t6_busy_idle", ib.busy, 0);
        chk("t6_frames", fd_b, 1);
        chk("t6_left_in_queue", exp_d_b.size(), 0);
        chk("t6_shutd", ib.shutd, 1);
        chk("t6_timeout_err", ib.timeout_err, 0);
        chk("t6_write", ib.write, 1);
        chk("t6_idle_pins", {ib.conv_start, ib.chip_sel, ib.read_s}, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/max11046_frame_reader.md
Name: max11046_frame_reader

Overview:
- Fully synchronous, parametrised controller for the MAX11046 simultaneous-sampling ADC.
- Issues CONVST, waits for the EOC falling edge, then reads NUM_CH channels over the parallel bus with CS/RD timing set in clock cycles.
- Delivers each sample as a tagged, one-cycle-valid word.
- Adds single-shot and continuous modes, an EOC timeout and a power-down request.
- Sits between the ADC pins and the force-sample buffer.

Parameters:
NUM_CH, 8, channels read per frame (1..8)
DATA_W, 16, ADC data bus width
CONV_LOW_CYC, 5, cycles CONVST held low per conversion (>=1)
CS_SETUP_CYC, 2, cycles CS low before first RD falling edge (>=1)
RD_LOW_CYC, 4, cycles RD held low per channel (>=1)
RD_HIGH_CYC, 2, cycles RD held high between channels (>=1)
EOC_TIMEOUT_CYC, 200, max cycles waiting for EOC low before abort
CH_W, $clog2(NUM_CH) min 1, channel index width

Ports:
clock1  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request for a frame; ignored while busy
cont_en  in  1  1 = start next frame automatically after DONE
pwr_down  in  1  shutdown request, sampled only in IDLE
end_of_con  in  1  ADC EOC, active low, asynchronous
db_in  in  DATA_W  ADC data bus
conv_start  out  1  ADC CONVST
chip_sel  out  1  ADC CS, active low
write  out  1  ADC WR, constant 1
read_s  out  1  ADC RD, active low
shutd  out  1  ADC shutdown pin, = ~pwr_down latched in IDLE
sample_data  out  DATA_W  captured conversion result
sample_ch  out  CH_W  channel of sample_data
sample_valid  out  1  one-cycle strobe, sample_data/sample_ch valid
frame_done  out  1  one-cycle strobe after last channel
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on EOC timeout, cleared by accepted start

Behaviour:
- Reset (async): conv_start=1, chip_sel=1, write=1, read_s=1, shutd=1, sample_data=0, sample_ch=0, sample_valid=0, frame_done=0, busy=0, timeout_err=0, state=IDLE. Asserting reset mid-frame returns all pins to these values immediately; no partial frame is reported.
- All outputs are registered.
- end_of_con passes through a 2-flop synchroniser. The EOC event is synced-low seen in WAIT_EOC; a level that is already low on entry also counts.
- IDLE: shutd <= ~pwr_down. If start=1 and pwr_down=0: clear timeout_err, enter CONV. start with pwr_down=1 is ignored.
- CONV: conv_start=0 for exactly CONV_LOW_CYC cycles, then enter WAIT_EOC with conv_start=1.
- WAIT_EOC: count cycles.
  - EOC event -> CS_SETUP.
  - Count reaching EOC_TIMEOUT_CYC -> timeout_err=1, return to IDLE (cont_en is not honoured).
- CS_SETUP: chip_sel=0 for CS_SETUP_CYC cycles -> RD_LOW, channel index=0.
- RD_LOW: read_s=0 for RD_LOW_CYC cycles.
  - On the last cycle, db_in is registered into sample_data and the index into sample_ch.
  - sample_valid is high on the next clock edge for exactly 1 cycle.
- RD_HIGH: read_s=1 for RD_HIGH_CYC cycles.
  - If index < NUM_CH-1: increment, go to RD_LOW.
  - Else: go to DONE.
- DONE (1 cycle): chip_sel=1, frame_done=1.
  - cont_en=1 and pwr_down=0 -> CONV.
  - Else -> IDLE.
- chip_sel stays low continuously from CS_SETUP through the last RD_HIGH.
- start is ignored outside IDLE.
- Frame length in cycles: CONV_LOW_CYC + EOC wait + CS_SETUP_CYC + NUM_CH*(RD_LOW_CYC+RD_HIGH_CYC) + 1.
- Index arithmetic is CH_W wide. NUM_CH=1 yields a single read with sample_ch=0.

Test Plan:
1. Defaults; start pulse; EOC driven low 20 cycles after conv_start rises; db_in = 16'hA000+channel during each RD low.
   -> Exactly 8 sample_valid strobes with ch 0..7 and data A000..A007.
   -> conv_start low exactly 5 cycles; each read_s low 4 / high 2 cycles; chip_sel low throughout; one frame_done; busy then 0.
2. EOC never asserted.
   -> timeout_err=1 200 cycles after entering WAIT_EOC; no sample_valid; chip_sel and read_s stay 1; back to IDLE. The next start clears timeout_err.
3. cont_en=1, three EOC responses.
   -> Three back-to-back frames, 24 samples; conv_start falls on the cycle after each frame_done.
   -> Dropping cont_en during frame 3 ends in IDLE after it.
4. reset asserted during the 4th RD_LOW.
   -> read_s, chip_sel, conv_start = 1 and busy=0 without waiting for a clock edge; no further sample_valid.
5. start repeated every cycle while busy.
   -> Ignored; exactly one frame per accepted start.
   -> pwr_down=1 in IDLE drives shutd=0 and blocks start.
6. NUM_CH=1, RD_LOW_CYC=1.
   -> Single sample, ch 0; frame_done one cycle after RD_HIGH ends.
